// File: rtl/radio_rx_framer.sv
// Radio receive framer: turns a strobed radio sample stream into packets for a
// burst command, with optional timed start, overflow and late reporting.
module radio_rx_framer #(
   parameter  int SAMP_W  = 32,
   parameter  int NSPC    = 1,
   parameter  int SPP     = 64,
   localparam int RADIO_W = SAMP_W * NSPC
) (
   input  logic               radio_clk,
   input  logic               radio_rst,
   input  logic [RADIO_W-1:0] radio_rx_data,
   input  logic               radio_rx_stb,
   input  logic [63:0]        radio_time,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [15:0]        cmd_num_words,
   input  logic               cmd_timed,
   input  logic [63:0]        cmd_time,
   output logic [RADIO_W-1:0] m_tdata,
   output logic [63:0]        m_ttimestamp,
   output logic               m_tlast,
   output logic               m_teob,
   output logic               m_tvalid,
   input  logic               m_tready,
   output logic               overflow,
   output logic               late
);

   localparam int             CNT_W    = (SPP > 1) ? $clog2(SPP) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SPP - 1);

   typedef enum logic [1:0] {IDLE, WAIT_TIME, RUN} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   word_cnt;
   logic [15:0]        remaining;
   logic [63:0]        start_time;
   logic               accept, cmd_zero, cmd_late;
   logic               capture_try, drop, capture, final_word, pkt_end;

   assign cmd_ready = (state == IDLE) && !radio_rst;

   // NOTE: every signal driven here gets its value before any branch, so no latch is inferred.
   always_comb begin
      state_next  = state;
      accept      = cmd_valid && cmd_ready;
      cmd_zero    = (cmd_num_words == 16'd0);
      cmd_late    = cmd_timed && (radio_time > cmd_time);
      capture_try = radio_rx_stb &&
                    ((state == RUN) || ((state == WAIT_TIME) && (radio_time >= start_time)));
      // A word arriving while the held word is stuck is dropped, never queued.
      drop        = capture_try && m_tvalid && !m_tready;
      capture     = capture_try && !drop;
      final_word  = (remaining == 16'd1);
      pkt_end     = final_word || (word_cnt == LAST_IDX);

      case (state)
         IDLE: begin
            if (accept && !cmd_zero && !cmd_late)
               state_next = cmd_timed ? WAIT_TIME : RUN;
         end
         WAIT_TIME, RUN: begin
            if (drop || (capture && final_word))
               state_next = IDLE;
            else if (capture)
               state_next = RUN;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge radio_clk) begin
      if (radio_rst) state <= IDLE;
      else           state <= state_next;
   end

   // NOTE: the output data registers are reset as well, so reset leaves a defined all-zero word.
   always_ff @(posedge radio_clk) begin
      if (radio_rst) begin
         word_cnt     <= '0;
         remaining    <= '0;
         start_time   <= '0;
         m_tdata      <= '0;
         m_ttimestamp <= '0;
         m_tlast      <= 1'b0;
         m_teob       <= 1'b0;
         m_tvalid     <= 1'b0;
         overflow     <= 1'b0;
         late         <= 1'b0;
      end else begin
         overflow <= drop;
         late     <= accept && !cmd_zero && cmd_late;

         if (accept) begin
            word_cnt   <= '0;
            remaining  <= cmd_num_words;
            start_time <= cmd_time;
         end

         if (capture) begin
            m_tdata  <= radio_rx_data;
            // Later words of a packet keep the timestamp already held from word 0.
            if (word_cnt == '0)
               m_ttimestamp <= radio_time;
            m_tlast   <= pkt_end;
            m_teob    <= final_word;
            m_tvalid  <= 1'b1;
            word_cnt  <= pkt_end ? '0 : word_cnt + CNT_W'(1);
            remaining <= remaining - 16'd1;
         end else if (drop) begin
            m_tlast <= 1'b1;
            m_teob  <= 1'b1;
         end else if (m_tready) begin
            m_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_radio_rx_framer.sv
// Self-checking bench for radio_rx_framer: a packetising reference model feeds
// a scoreboard queue that an independent output monitor drains and compares.
module tb_radio_rx_framer;

   localparam int SAMP_W = 32;
   localparam int NSPC   = 1;
   localparam int SPP    = 4;
   localparam int RW     = SAMP_W * NSPC;

   logic          radio_clk = 1'b0;
   logic          radio_rst;
   logic [RW-1:0] radio_rx_data;
   logic          radio_rx_stb;
   logic [63:0]   radio_time;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [15:0]   cmd_num_words;
   logic          cmd_timed;
   logic [63:0]   cmd_time;
   logic [RW-1:0] m_tdata;
   logic [63:0]   m_ttimestamp;
   logic          m_tlast;
   logic          m_teob;
   logic          m_tvalid;
   logic          m_tready;
   logic          overflow;
   logic          late;

   radio_rx_framer #(.SAMP_W(SAMP_W), .NSPC(NSPC), .SPP(SPP)) dut (
      .radio_clk     (radio_clk),
      .radio_rst     (radio_rst),
      .radio_rx_data (radio_rx_data),
      .radio_rx_stb  (radio_rx_stb),
      .radio_time    (radio_time),
      .cmd_valid     (cmd_valid),
      .cmd_ready     (cmd_ready),
      .cmd_num_words (cmd_num_words),
      .cmd_timed     (cmd_timed),
      .cmd_time      (cmd_time),
      .m_tdata       (m_tdata),
      .m_ttimestamp  (m_ttimestamp),
      .m_tlast       (m_tlast),
      .m_teob        (m_teob),
      .m_tvalid      (m_tvalid),
      .m_tready      (m_tready),
      .overflow      (overflow),
      .late          (late)
   );

   always #5 radio_clk = ~radio_clk;

   typedef struct {
      logic [RW-1:0] data;
      logic [63:0]   ts;
      logic          last;
      logic          eob;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          pops = 0, n_last = 0, n_eob = 0, ovf_cnt = 0, late_cnt = 0;
   bit          new_burst = 1'b1;
   logic [63:0] burst_ts0 = '0;
   logic [63:0] rt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Output monitor: pops the scoreboard on every handshake.
   initial begin
      exp_t          e;
      bit            hold_prev;
      logic [RW-1:0] d_prev;
      logic [63:0]   ts_prev;
      hold_prev = 1'b0;
      d_prev    = '0;
      ts_prev   = '0;
      forever begin
         @(negedge radio_clk);
         if (overflow === 1'b1) ovf_cnt++;
         if (late === 1'b1) late_cnt++;
         if (radio_rst === 1'b1) new_burst = 1'b1;
         if (hold_prev && m_tvalid === 1'b1) begin
            check("hold_stable_data", m_tdata, d_prev);
            check("hold_stable_ts", m_ttimestamp, ts_prev);
         end
         if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data %0h, expected no output", m_tdata);
            end else begin
               e = exp_q.pop_front();
               check("word_data", m_tdata, e.data);
               check("word_ts", m_ttimestamp, e.ts);
               check("word_tlast", m_tlast, e.last);
               check("word_teob", m_teob, e.eob);
            end
            pops++;
            if (m_tlast) n_last++;
            if (m_teob) n_eob++;
            if (new_burst) burst_ts0 = m_ttimestamp;
            new_burst = m_teob;
         end
         hold_prev = (m_tvalid === 1'b1) && (m_tready !== 1'b1);
         d_prev    = m_tdata;
         ts_prev   = m_ttimestamp;
      end
   end

   task automatic tick();
      @(posedge radio_clk);
      #1;
   endtask

   task automatic issue_cmd(input int n, input bit timed, input logic [63:0] tcmd);
      int w = 0;
      while (cmd_ready !== 1'b1 && w < 50) begin
         tick();
         w++;
      end
      check("cmd_ready_before_accept", cmd_ready, 1);
      cmd_valid     = 1'b1;
      cmd_num_words = 16'(n);
      cmd_timed     = timed;
      cmd_time      = tcmd;
      radio_rx_stb  = 1'b0;
      radio_time    = rt;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Reference model: the burst is the first n strobes from the cycle after
   // accept (timed: from the first strobe at or past tcmd), cut into SPP chunks.
   task automatic run_burst(input int n, input bit timed, input logic [63:0] tcmd, input bit rnd);
      int            k = 0;
      int            cyc = 0;
      bit            started;
      bit            stb;
      logic [63:0]   pkt_t = '0;
      logic [RW-1:0] d;
      started = !timed;
      issue_cmd(n, timed, tcmd);
      while (k < n && cyc < 20000) begin
         stb           = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         m_tready      = (stb || !rnd) ? 1'b1 : 1'($urandom_range(0, 1));
         d             = $urandom;
         radio_rx_data = d;
         radio_rx_stb  = stb;
         radio_time    = rt;
         if (stb && (started || rt >= tcmd)) begin
            started = 1'b1;
            if (k % SPP == 0) pkt_t = rt;
            exp_q.push_back('{d, pkt_t, (k % SPP == SPP - 1) || (k == n - 1), k == n - 1});
            k++;
         end
         tick();
         if (stb) rt += 2;
         cyc++;
      end
      radio_rx_stb = 1'b0;
      m_tready     = 1'b1;
   endtask

   task automatic drain();
      int w = 0;
      while (exp_q.size() != 0 && w < 200) begin
         tick();
         w++;
      end
      check("drain_queue_empty", exp_q.size(), 0);
      repeat (3) tick();
   endtask

   initial begin
      int            bp, bl, be, bo, bla;
      logic [RW-1:0] d;
      radio_rst     = 1'b1;
      cmd_valid     = 1'b0;
      cmd_num_words = '0;
      cmd_timed     = 1'b0;
      cmd_time      = '0;
      radio_rx_stb  = 1'b0;
      radio_rx_data = '0;
      radio_time    = '0;
      m_tready      = 1'b1;
      rt            = '0;

      tick();
      check("cmd_ready_in_reset", cmd_ready, 0);
      check("tvalid_in_reset", m_tvalid, 0);
      radio_rst = 1'b0;
      tick();
      check("cmd_ready_after_reset", cmd_ready, 1);
      check("reset_tdata", m_tdata, 0);
      check("reset_ts", m_ttimestamp, 0);
      check("reset_tlast", m_tlast, 0);
      check("reset_teob", m_teob, 0);
      check("reset_overflow", overflow, 0);
      check("reset_late", late, 0);

      // Untimed 10-word burst, SPP=4: packets of 4, 4, 2.
      bp = pops; bl = n_last; be = n_eob;
      run_burst(10, 1'b0, 64'd0, 1'b0);
      drain();
      check("burst10_words", pops - bp, 10);
      check("burst10_tlast_count", n_last - bl, 3);
      check("burst10_teob_count", n_eob - be, 1);

      // Timed starts on an even-stepping clock.
      rt = '0;
      run_burst(6, 1'b1, 64'd100, 1'b0);
      drain();
      check("timed_100_first_ts", burst_ts0, 100);
      rt = '0;
      run_burst(6, 1'b1, 64'd101, 1'b0);
      drain();
      check("timed_101_first_ts", burst_ts0, 102);

      // Late timed command.
      bp = pops; bla = late_cnt;
      rt = 64'd20;
      issue_cmd(5, 1'b1, 64'd10);
      radio_rx_stb = 1'b1;
      repeat (4) tick();
      radio_rx_stb = 1'b0;
      tick();
      check("late_pulses", late_cnt - bla, 1);
      check("late_no_output", pops - bp, 0);
      check("late_tvalid", m_tvalid, 0);
      check("late_cmd_ready", cmd_ready, 1);

      // Zero-length command.
      bp = pops; bla = late_cnt; bo = ovf_cnt;
      issue_cmd(0, 1'b0, 64'd0);
      radio_rx_stb = 1'b1;
      repeat (3) tick();
      radio_rx_stb = 1'b0;
      tick();
      check("zero_no_output", pops - bp, 0);
      check("zero_no_late", late_cnt - bla, 0);
      check("zero_no_overflow", ovf_cnt - bo, 0);
      check("zero_cmd_ready", cmd_ready, 1);

      // Backpressure overflow: held word becomes end of burst.
      bp = pops; be = n_eob; bo = ovf_cnt;
      issue_cmd(10, 1'b0, 64'd0);
      d = $urandom;
      radio_rx_data = d; radio_time = rt; radio_rx_stb = 1'b1; m_tready = 1'b1;
      exp_q.push_back('{d, rt, 1'b1, 1'b1});
      tick();
      rt += 2;
      m_tready = 1'b0;
      repeat (3) begin
         radio_rx_data = $urandom;
         radio_time    = rt;
         tick();
         rt += 2;
      end
      radio_rx_stb = 1'b0;
      m_tready     = 1'b1;
      drain();
      check("ovf_pulses", ovf_cnt - bo, 1);
      check("ovf_words", pops - bp, 1);
      check("ovf_teob_count", n_eob - be, 1);
      check("ovf_cmd_ready", cmd_ready, 1);

      // Reset mid-burst discards the pending word.
      bp = pops; be = n_eob;
      issue_cmd(10, 1'b0, 64'd0);
      d = $urandom;
      radio_rx_data = d; radio_time = rt; radio_rx_stb = 1'b1; m_tready = 1'b1;
      exp_q.push_back('{d, rt, 1'b0, 1'b0});
      tick();
      rt += 2;
      radio_rx_data = $urandom; radio_time = rt;
      tick();
      rt += 2;
      radio_rx_stb = 1'b0; m_tready = 1'b0; radio_rst = 1'b1;
      tick();
      check("midreset_cmd_ready", cmd_ready, 0);
      radio_rst = 1'b0;
      check("midreset_tvalid", m_tvalid, 0);
      check("midreset_teob", m_teob, 0);
      check("midreset_tdata", m_tdata, 0);
      m_tready = 1'b1;
      tick();
      check("midreset_cmd_ready_after", cmd_ready, 1);
      drain();
      check("midreset_words", pops - bp, 1);
      check("midreset_no_teob", n_eob - be, 0);

      // Random strobes and back-pressure without overflow.
      bp = pops; bo = ovf_cnt; bla = late_cnt;
      run_burst(1000, 1'b0, 64'd0, 1'b1);
      drain();
      check("random_words", pops - bp, 1000);
      repeat (6) begin
         int          n;
         bit          timed;
         logic [63:0] tcmd;
         n     = $urandom_range(1, 12);
         timed = 1'($urandom_range(0, 1));
         tcmd  = rt + 64'($urandom_range(0, 20));
         run_burst(n, timed, tcmd, 1'b1);
         drain();
      end
      check("random_no_overflow", ovf_cnt - bo, 0);
      check("random_no_late", late_cnt - bla, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
